action_exec: RTL

//  Stage directly downstream of the table-lookup stage. Consumes {wr,ctl,data}

---
 rtl/action_exec_if.sv | 34 +++
 rtl/action_exec.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/action_exec_if.sv
// Handshake bundle between the lookup stage, the action executor and the output-queue stage.
// The upstream side has no backpressure; the downstream side is valid/ready.
interface action_exec_if #(
    parameter int DATA_WIDTH = 480,
    parameter int CTRL_WIDTH = 32
);
    logic                  in_wr;
    logic [CTRL_WIDTH-1:0] in_ctl;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_wr;
    logic [CTRL_WIDTH-1:0] out_ctl;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_rdy;

    modport master (
        output in_wr,
        output in_ctl,
        output in_data,
        output out_rdy,
        input  out_wr,
        input  out_ctl,
        input  out_data
    );

    modport slave (
        input  in_wr,
        input  in_ctl,
        input  in_data,
        input  out_rdy,
        output out_wr,
        output out_ctl,
        output out_data
    );
endinterface

// File: rtl/action_exec.sv
// Action executor: buffers header words in a small FIFO, applies forward/drop/TTL/punt
// and holds each surviving word on the output until the output-queue stage accepts it.
module action_exec #(
    parameter int           DATA_WIDTH = 480,
    parameter int           CTRL_WIDTH = 32,
    parameter int           FIFO_AW    = 2,
    parameter int           TTL_LSB    = 176,
    parameter logic [7:0]   CPU_MASK   = 8'h80,
    parameter int           CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    action_exec_if.slave         bus,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [CNT_WIDTH-1:0] ovf_cnt
);
    localparam int                 DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;
    localparam logic [FIFO_AW:0]   CNT_ONE   = 1;
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] STAT_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CTRL_WIDTH-1:0] r_mem_ctl  [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [FIFO_AW-1:0]    r_wr_ptr;
    logic [FIFO_AW-1:0]    r_rd_ptr;
    logic [FIFO_AW:0]      r_count;

    logic [CTRL_WIDTH-1:0] r_exec_ctl;
    logic [DATA_WIDTH-1:0] r_exec_data;
    logic                  r_out_wr;
    logic [CTRL_WIDTH-1:0] r_out_ctl;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_ovf;
    logic                  w_pop;
    logic                  w_fwd;
    logic                  w_drop;
    logic                  w_accept;
    logic [7:0]            w_ttl;
    logic                  w_res_drop;
    logic [CTRL_WIDTH-1:0] w_res_ctl;
    logic [DATA_WIDTH-1:0] w_res_data;
    logic [2:0]            w_cnt_inc;

    // Full is judged on the pre-edge occupancy, so a same-edge pop never rescues a write.
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_wr && !w_full;
    assign w_ovf   = bus.in_wr && w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ctl[r_wr_ptr]  <= bus.in_ctl;
            r_mem_data[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_exec_ctl  <= '0;
            r_exec_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PTR_ONE;
                r_exec_ctl  <= r_mem_ctl[r_rd_ptr];
                r_exec_data <= r_mem_data[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Action result for the word sitting in the exec register.
    always_comb begin
        w_res_ctl  = r_exec_ctl;
        w_res_data = r_exec_data;
        w_res_drop = 1'b0;
        w_ttl      = r_exec_data[TTL_LSB +: 8];
        case (r_exec_ctl[17:16])
            2'd1: w_res_drop = 1'b1;
            2'd2: begin
                if (w_ttl <= 8'd1) begin
                    w_res_drop = 1'b1;
                end else begin
                    w_res_data[TTL_LSB +: 8] = w_ttl - 8'd1;
                end
            end
            2'd3:    w_res_ctl[15:8] = CPU_MASK;
            default: w_res_drop = 1'b0;
        endcase
        w_res_ctl[17:16] = 2'b00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_fwd        = 1'b0;
        w_drop       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_res_drop) begin
                    w_drop = 1'b1;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_EXEC;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_fwd        = 1'b1;
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_rdy) begin
                    w_accept = 1'b1;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_EXEC;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_wr   <= 1'b0;
            r_out_ctl  <= '0;
            r_out_data <= '0;
        end else if (w_fwd) begin
            r_out_wr   <= 1'b1;
            r_out_ctl  <= w_res_ctl;
            r_out_data <= w_res_data;
        end else if (w_accept) begin
            r_out_wr <= 1'b0;
        end
    end

    assign bus.out_wr   = r_out_wr;
    assign bus.out_ctl  = r_out_ctl;
    assign bus.out_data = r_out_data;

    // Index 0: forwarded, 1: dropped by action, 2: lost to a full FIFO.
    assign w_cnt_inc = {w_ovf, w_drop, w_fwd};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_WIDTH-1:0] r_val;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_val <= '0;
            end else if (w_cnt_inc[gi] && (r_val != '1)) begin
                r_val <= r_val + STAT_ONE;
            end
        end
    end

    assign pkt_cnt  = g_cnt[0].r_val;
    assign drop_cnt = g_cnt[1].r_val;
    assign ovf_cnt  = g_cnt[2].r_val;
endmodule
